// File: rtl/dh_responder.sv
// rtl/dh_responder.sv - Diffie-Hellman responder with constant-time modular exponentiation
module dh_responder #(
  parameter int W = 8,
  parameter int P = 23,
  parameter int G = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] priv,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  output logic         b_valid,
  output logic [W-1:0] b_data,
  input  logic         b_ready,
  output logic         key_valid,
  output logic [W-1:0] key,
  output logic         err,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, EXP_B, SEND_B, EXP_K, DONE} state_t;

  localparam int              CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0]      PW   = (W+1)'(P);
  localparam logic [W-1:0]    GW   = W'(G);
  localparam logic [W-1:0]    ONE  = W'(1);
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  state_t        state, state_next;
  logic [W-1:0]  a_reg, e_reg, r, acc;
  logic [CW-1:0] bit_idx, mstep;
  logic          phase;  // 0: square step, 1: multiply-by-base step

  logic          a_accept, a_bad;
  logic [W-1:0]  base, y_op, acc_in, prod, final_val;
  logic [W:0]    dbl, red1, sum, red2;
  logic          y_bit, e_bit, mul_done, exp_done;
  logic [CW-1:0] y_idx, e_idx;

  assign a_ready  = (state == IDLE) || (state == DONE);
  assign b_valid  = (state == SEND_B);
  assign busy     = (state == EXP_B) || (state == EXP_K);
  assign a_accept = a_valid && a_ready;
  assign a_bad    = (a_data == '0) || ({1'b0, a_data} >= PW);

  // One shift-add multiplier step: acc = 2*acc (+ r if y bit set), kept reduced below P
  always_comb begin
    base      = (state == EXP_K) ? a_reg : GW;
    y_op      = phase ? base : r;
    y_idx     = LAST - mstep;
    e_idx     = LAST - bit_idx;
    y_bit     = y_op[y_idx];
    e_bit     = e_reg[e_idx];
    acc_in    = (mstep == '0) ? '0 : acc;
    dbl       = {acc_in, 1'b0};
    red1      = (dbl >= PW) ? (dbl - PW) : dbl;
    sum       = red1 + {1'b0, r};
    red2      = (sum >= PW) ? (sum - PW) : sum;
    prod      = y_bit ? red2[W-1:0] : red1[W-1:0];
    mul_done  = (mstep == LAST);
    exp_done  = mul_done && phase && (bit_idx == LAST);
    // The multiply result is computed every bit and only selected by the exponent bit
    final_val = e_bit ? prod : r;
  end

  // State register; reset aborts any exchange in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (a_accept) state_next = a_bad ? IDLE : EXP_B;
      end
      EXP_B:  if (exp_done) state_next = SEND_B;
      SEND_B: if (b_ready)  state_next = EXP_K;
      EXP_K:  if (exp_done) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, exponentiation sequencing and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      e_reg     <= '0;
      r         <= ONE;
      acc       <= '0;
      bit_idx   <= '0;
      mstep     <= '0;
      phase     <= 1'b0;
      b_data    <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (a_accept) begin
        key_valid <= 1'b0;
        if (a_bad) begin
          err <= 1'b1;
        end else begin
          a_reg   <= a_data;
          e_reg   <= priv;
          r       <= ONE;
          bit_idx <= '0;
          mstep   <= '0;
          phase   <= 1'b0;
        end
      end else if (busy) begin
        acc   <= prod;
        mstep <= mul_done ? '0 : mstep + 1'b1;
        if (mul_done) begin
          if (!phase) begin
            r     <= prod;
            phase <= 1'b1;
          end else begin
            r       <= final_val;
            phase   <= 1'b0;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        if (exp_done) begin
          if (state == EXP_B) begin
            b_data <= final_val;
          end else begin
            key       <= final_val;
            key_valid <= 1'b1;
          end
        end
      end else if (b_valid && b_ready) begin
        r       <= ONE;
        bit_idx <= '0;
        mstep   <= '0;
        phase   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dh_responder.sv
// tb/tb_dh_responder.sv - directed self-checking bench for dh_responder
module tb_dh_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] priv = '0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key;
  logic       err;
  logic       busy;

  int total = 0;
  int bad = 0;

  dh_responder #(.W(8), .P(23), .G(5)) dut (
    .clk(clk), .rst(rst), .priv(priv),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .key_valid(key_valid), .key(key), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full exchange; hold=0 means b_ready is tied high from the start
  task automatic exchange(input logic [7:0] pv, input logic [7:0] av,
                          input logic [7:0] eb, input logic [7:0] ek,
                          input int hold, input bit poke);
    int pre;
    @(negedge clk);
    b_ready = (hold == 0);
    chk("a_ready_before", a_ready, 1);
    priv = pv; a_data = av; a_valid = 1'b1;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("key_valid_after_accept", key_valid, 0);
    chk("busy_exp_b", busy, 1);
    chk("a_ready_exp_b", a_ready, 0);
    pre = 0;
    if (poke) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'd3;
        chk("a_ready_ignored", a_ready, 0);
      end
      a_valid = 1'b0;
      pre = 5;
    end
    repeat (127 - pre) @(negedge clk);
    chk("b_valid_early", b_valid, 0);
    @(negedge clk);
    chk("b_valid_rise", b_valid, 1);
    chk("b_data", b_data, eb);
    chk("busy_send_b", busy, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("b_valid_hold", b_valid, 1);
      chk("b_data_hold", b_data, eb);
    end
    b_ready = 1'b1;
    @(posedge clk); #1 b_ready = 1'b0;
    @(negedge clk);
    chk("b_valid_drop", b_valid, 0);
    chk("busy_exp_k", busy, 1);
    repeat (127) @(negedge clk);
    chk("key_valid_early", key_valid, 0);
    @(negedge clk);
    chk("key_valid_rise", key_valid, 1);
    chk("key", key, ek);
    chk("busy_done", busy, 0);
  endtask

  task automatic reject(input logic [7:0] av, input logic [7:0] prev_key);
    @(negedge clk);
    a_data = av; a_valid = 1'b1;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("a_ready_reject", a_ready, 1);
    chk("key_valid_reject", key_valid, 0);
    chk("key_kept", key, prev_key);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    chk("b_valid_reject", b_valid, 0);
    chk("busy_reject", busy, 0);
  endtask

  initial begin
    #1;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key", key, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 5^15 mod 23 = 19, 8^15 mod 23 = 2
    exchange(8'd15, 8'd8, 8'd19, 8'd2, 0, 1'b0);
    reject(8'd0, 8'd2);
    reject(8'd23, 8'd2);
    exchange(8'd15, 8'd8, 8'd19, 8'd2, 50, 1'b0);
    // priv = 0 gives unity; stray a_valid during EXP_B must be ignored
    exchange(8'd0, 8'd8, 8'd1, 8'd1, 0, 1'b1);
    // Back-to-back from DONE: 5^6 mod 23 = 8, 19^6 mod 23 = 2
    exchange(8'd6, 8'd19, 8'd8, 8'd2, 0, 1'b0);

    // Reset in the middle of EXP_K
    @(negedge clk);
    priv = 8'd15; a_data = 8'd8; a_valid = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1 a_valid = 1'b0;
    repeat (130) @(negedge clk);
    b_ready = 1'b0;
    chk("mid_exp_k_busy", busy, 1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_b_valid", b_valid, 0);
    chk("arst_b_data", b_data, 0);
    chk("arst_key_valid", key_valid, 0);
    chk("arst_key", key, 0);
    chk("arst_a_ready", a_ready, 1);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    exchange(8'd6, 8'd19, 8'd8, 8'd2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
